// File: rtl/vp_mac_stream_packer.sv
`default_nettype none
//=============================================================================
// Module      : vp_mac_stream_packer
// Description : Upstream feeder for the temporal variable-precision MAC.
//               Merges one job request, an activation byte stream and a
//               weight byte stream into the MAC's single slave stream.
//               Per job it emits a precision beat (tuser=1), a dequant-scale
//               beat, then cfg_len data beats {act,wgt} with tlast on the
//               final data beat. One job in flight at a time.
// Ports       : clk, rst_n (async, active-low)
//               cfg_*        job request (valid/ready + precision/scale/len/tid)
//               sa_axis_*    activation stream in (8-bit)
//               sw_axis_*    weight stream in (8-bit)
//               mo_axis_*    packed stream out to the MAC (single reg slot)
//               err_cfg      1-cycle pulse when a job request is rejected
// Revision    : 1.0 - initial release
//=============================================================================
module vp_mac_stream_packer #(
    parameter int AXIS_DW = 32,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [3:0]         cfg_precision,
    input  logic [31:0]        cfg_scale,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [7:0]         cfg_tid,
    input  logic               sa_axis_tvalid,
    output logic               sa_axis_tready,
    input  logic [7:0]         sa_axis_tdata,
    input  logic               sw_axis_tvalid,
    output logic               sw_axis_tready,
    input  logic [7:0]         sw_axis_tdata,
    output logic               mo_axis_tvalid,
    input  logic               mo_axis_tready,
    output logic [AXIS_DW-1:0] mo_axis_tdata,
    output logic               mo_axis_tlast,
    output logic               mo_axis_tuser,
    output logic [7:0]         mo_axis_tid,
    output logic               err_cfg
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HDR_PREC  = 2'd1;
    localparam logic [1:0] ST_HDR_SCALE = 2'd2;
    localparam logic [1:0] ST_PAIR      = 2'd3;

    logic [1:0]       state;
    logic             alive;      // holds cfg_ready low while in reset
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len;
    logic [3:0]       prec;
    logic [31:0]      scale;
    logic [7:0]       tid;

    logic slot_free;
    logic cfg_fire;
    logic cfg_bad;
    logic pair_fire;
    logic last_pair;

    assign slot_free = !mo_axis_tvalid || mo_axis_tready;
    assign cfg_ready = alive && (state == ST_IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_bad   = (cfg_len == '0) || (cfg_precision > 4'd8);

    // Joint handshake: a pair is consumed only when both bytes are present
    // and the output slot can take the packed beat, so streams never skew.
    assign pair_fire      = (state == ST_PAIR) && sa_axis_tvalid && sw_axis_tvalid && slot_free;
    assign sa_axis_tready = pair_fire;
    assign sw_axis_tready = pair_fire;

    // count runs 0..len-1 and len >= 1, so len-1 never underflows and the
    // full-scale length completes without the counter wrapping.
    assign last_pair = (count == (len - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            alive          <= 1'b0;
            count          <= '0;
            len            <= '0;
            prec           <= '0;
            scale          <= '0;
            tid            <= '0;
            mo_axis_tvalid <= 1'b0;
            mo_axis_tdata  <= '0;
            mo_axis_tlast  <= 1'b0;
            mo_axis_tuser  <= 1'b0;
            mo_axis_tid    <= '0;
            err_cfg        <= 1'b0;
        end else begin
            alive   <= 1'b1;
            err_cfg <= 1'b0;

            // Slot drains on handshake; any load below overrides this.
            if (mo_axis_tvalid && mo_axis_tready) begin
                mo_axis_tvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        if (cfg_bad) begin
                            err_cfg <= 1'b1;
                        end else begin
                            prec  <= cfg_precision;
                            scale <= cfg_scale;
                            len   <= cfg_len;
                            tid   <= cfg_tid;
                            count <= '0;
                            // Load the precision beat straight from the request
                            // so back-to-back jobs stream without a bubble.
                            if (slot_free) begin
                                mo_axis_tvalid <= 1'b1;
                                mo_axis_tdata  <= AXIS_DW'(cfg_precision);
                                mo_axis_tuser  <= 1'b1;
                                mo_axis_tlast  <= 1'b0;
                                mo_axis_tid    <= cfg_tid;
                                state          <= ST_HDR_SCALE;
                            end else begin
                                state <= ST_HDR_PREC;
                            end
                        end
                    end
                end

                ST_HDR_PREC: begin
                    if (slot_free) begin
                        mo_axis_tvalid <= 1'b1;
                        mo_axis_tdata  <= AXIS_DW'(prec);
                        mo_axis_tuser  <= 1'b1;
                        mo_axis_tlast  <= 1'b0;
                        mo_axis_tid    <= tid;
                        state          <= ST_HDR_SCALE;
                    end
                end

                ST_HDR_SCALE: begin
                    if (slot_free) begin
                        mo_axis_tvalid <= 1'b1;
                        mo_axis_tdata  <= AXIS_DW'(scale);
                        mo_axis_tuser  <= 1'b0;
                        mo_axis_tlast  <= 1'b0;
                        mo_axis_tid    <= tid;
                        state          <= ST_PAIR;
                    end
                end

                ST_PAIR: begin
                    if (pair_fire) begin
                        mo_axis_tvalid <= 1'b1;
                        mo_axis_tdata  <= AXIS_DW'({sa_axis_tdata, sw_axis_tdata});
                        mo_axis_tuser  <= 1'b0;
                        mo_axis_tlast  <= last_pair;
                        mo_axis_tid    <= tid;
                        count          <= count + LEN_W'(1);
                        if (last_pair) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
